x_pair_transmitter: RTL and testbench
=====================================

// Module: x_pair_transmitter
// PURPOSE
//  Transmit side of the two-wire X_1/X_2 symbol interface into my_counter.
//  Accepts a DATA_W-bit word over a valid/ready handshake and serializes it
//  MSB-first as 2-bit symbols {x_1,x_2}, one symbol per clk.
//  Inserts an idle gap between words. Optionally tracks the counter's
//  state to predict its out_z.
// PARAMETERS
//  DATA_W      8      word width; even, >=2; symbols per word = DATA_W/2
//  GAP_CYCLES  1      idle-symbol cycles after each word; 0 = none
//  IDLE_SYM    2'b00  {x_1,x_2} driven whenever no data symbol is on the wire
// PORTS
//  clk       in   1       rising-edge clock
//  rst       in   1       synchronous reset, active-high
//  in_valid  in   1       word offered
//  in_ready  out  1       word accepted when in_valid & in_ready
//  in_data   in   DATA_W  word to send; sampled only on handshake
//  x_1       out  1       symbol bit 1 (upper bit of the pair), registered
//  x_2       out  1       symbol bit 0 (lower bit of the pair), registered
//  sym_valid out  1       x_1/x_2 carry a data symbol this cycle
//  last      out  1       final symbol of the word; only with sym_valid
//  busy      out  1       state != IDLE
//  pred_z    out  1       predicted receiver out_z (SHADOW_FSM_EN only)
// BEHAVIOUR
//  - State machine: IDLE -> SEND -> GAP -> IDLE.
//  - Reset (rst=1 at edge): state=IDLE, {x_1,x_2}=IDLE_SYM, sym_valid=0,
//    last=0, busy=0, symbol count=0, shift register=0.
//  - Reset mid-word aborts the word at once: no last, and the word is not resent.
//  - in_ready = (state==IDLE), combinational from state; it is 1 in the
//    cycle after reset. in_ready never depends on in_valid.
//  - IDLE: on handshake, capture in_data and go to SEND.
//    The first symbol in_data[DATA_W-1:DATA_W-2] is on the wire next cycle
//    (latency 1). Later changes to in_data are ignored.
//  - SEND: lasts exactly DATA_W/2 cycles; sym_valid=1 throughout.
//    Symbol k (k=0..DATA_W/2-1) = word[DATA_W-1-2k -: 2].
//    last=1 on symbol DATA_W/2-1 only.
//  - After the last symbol: go to GAP if GAP_CYCLES>0, else IDLE.
//  - GAP: GAP_CYCLES cycles with IDLE_SYM, sym_valid=0, in_ready=0; then IDLE.
//  - Outside SEND, the wire is always IDLE_SYM with sym_valid=0.
//  - Back-to-back words, GAP_CYCLES=0: next handshake falls in the IDLE
//    cycle, so there is exactly 1 idle-symbol cycle between words.
//  - Symbol count width = clog2(DATA_W/2), minimum 1. Counter wrap is
//    never observable.
// CONFIGURATION
//  SHADOW_FSM_EN defined: 2-bit register pq={q1,q2}, reset 00, updated on
//   EVERY clk (idle cycles included) from the x_1/x_2 currently driven:
//     q1' = x1&x2&q1 | q1&q2 | x1&q2
//     q2' = x1&~q1 | q2&~x1 | x2&~q1 | x1&~x2&~q2
//   pred_z = q1&q2. Transmitter flow is unaffected.
//  SHADOW_FSM_EN undefined: pq register and pred_z port are absent;
//   all other behaviour is identical.
// TESTING (DATA_W=8, GAP_CYCLES=1, IDLE_SYM=00 unless noted)
//  1. Reset, then in_valid=1, in_data=8'hB4 at cycle 0:
//     cycles 1-4 give {x_1,x_2}=10,11,01,00 with sym_valid=1;
//     last=1 in cycle 4 only; cycle 5 is GAP; in_ready=1 again in cycle 6.
//  2. in_valid held high with 8'hFF then 8'h00:
//     second word accepted in cycle 6; its symbols appear in cycles 7-10;
//     in_ready=0 in cycles 1-5.
//  3. rst=1 in cycle 2 of a word: next cycle wire=00, sym_valid=0, last
//     never asserted, in_ready=1; a new word then sends correctly.
//  4. GAP_CYCLES=0, back-to-back 8'h5A, 8'hC3: symbols 01,01,10,10,
//     then 1 idle cycle, then 11,00,00,11.
//  5. SHADOW_FSM_EN, 8'hFF from reset: pq=01 in cycle 2, 11 in cycle 3,
//     10 in cycles 4-5, then 00 after the gap.
//     pred_z=1 in cycle 3 only.
//  6. in_valid=0 for 20 cycles: wire stays 00, sym_valid=0, busy=0,
//     in_ready=1, pred_z=0.

Source files
------------

// File: rtl/x_pair_transmitter_if.sv
// Word handshake and symbol wire bundle for x_pair_transmitter.
// slave = transmitter side, master = word source / wire observer.
interface x_pair_transmitter_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              x_1;
  logic              x_2;
  logic              sym_valid;
  logic              last;
  logic              busy;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output x_1,
    output x_2,
    output sym_valid,
    output last,
    output busy
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  x_1,
    input  x_2,
    input  sym_valid,
    input  last,
    input  busy
  );
endinterface

// File: rtl/x_pair_transmitter.sv
// Serializes words MSB-first as {x_1,x_2} symbols with an idle gap.
// Optional SHADOW_FSM_EN adds the receiver shadow state and pred_z.
module x_pair_transmitter #(
  parameter int         DATA_W     = 8,
  parameter int         GAP_CYCLES = 1,
  parameter logic [1:0] IDLE_SYM   = 2'b00
) (
  input  logic clk,
  input  logic rst,
  x_pair_transmitter_if.slave bus
`ifdef SHADOW_FSM_EN
  ,
  output logic pred_z
`endif
);

  localparam int NSYM = DATA_W / 2;
  localparam int CW   = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam int GW   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [GW-1:0]     gcnt;
  logic [DATA_W-1:0] shreg;
  logic [1:0]        sym_q;
  logic              sv_q;
  logic              last_q;

  assign bus.in_ready  = (state == IDLE);
  assign bus.busy      = (state != IDLE);
  assign bus.x_1       = sym_q[1];
  assign bus.x_2       = sym_q[0];
  assign bus.sym_valid = sv_q;
  assign bus.last      = last_q;

  // Main FSM; the wire outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      gcnt   <= '0;
      shreg  <= '0;
      sym_q  <= IDLE_SYM;
      sv_q   <= 1'b0;
      last_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            shreg  <= bus.in_data << 2;
            sym_q  <= bus.in_data[DATA_W-1 -: 2];
            sv_q   <= 1'b1;
            last_q <= (NSYM == 1);
            cnt    <= '0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (cnt == CW'(NSYM - 1)) begin
            sym_q  <= IDLE_SYM;
            sv_q   <= 1'b0;
            last_q <= 1'b0;
            gcnt   <= '0;
            state  <= (GAP_CYCLES > 0) ? GAP : IDLE;
          end else begin
            sym_q  <= shreg[DATA_W-1 -: 2];
            shreg  <= shreg << 2;
            cnt    <= cnt + 1'b1;
            last_q <= (cnt == CW'(NSYM - 2));
          end
        end
        GAP: begin
          if (gcnt == GW'(GAP_CYCLES - 1)) begin
            state <= IDLE;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SHADOW_FSM_EN
  logic [1:0] pq;
  logic       x1;
  logic       x2;

  assign x1     = sym_q[1];
  assign x2     = sym_q[0];
  assign pred_z = pq[1] & pq[0];

  // Receiver state model, advanced by whatever symbol is on the wire.
  always_ff @(posedge clk) begin
    if (rst) begin
      pq <= 2'b00;
    end else begin
      pq[1] <= (x1 & x2 & pq[1]) | (pq[1] & pq[0]) | (x1 & pq[0]);
      pq[0] <= (x1 & ~pq[1]) | (pq[0] & ~x1) | (x2 & ~pq[1])
             | (x1 & ~x2 & ~pq[0]);
    end
  end
`endif

endmodule

// File: tb/tb_x_pair_transmitter.sv
// Self-checking bench for x_pair_transmitter.
// DUT a: GAP_CYCLES=1, DUT b: GAP_CYCLES=0.
module tb_x_pair_transmitter;

  typedef struct {
    int         cyc;
    logic [1:0] sym;
    logic       last;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  bit   mon_en;

  exp_t qa[$];
  exp_t qb[$];

  x_pair_transmitter_if #(.DATA_W(8)) a_if ();
  x_pair_transmitter_if #(.DATA_W(8)) b_if ();

`ifdef SHADOW_FSM_EN
  logic pz_a;
  logic pz_b;
`endif

  x_pair_transmitter #(
    .DATA_W(8), .GAP_CYCLES(1), .IDLE_SYM(2'b00)
  ) u_a (
    .clk(clk),
    .rst(rst),
    .bus(a_if.slave)
`ifdef SHADOW_FSM_EN
    ,
    .pred_z(pz_a)
`endif
  );

  x_pair_transmitter #(
    .DATA_W(8), .GAP_CYCLES(0), .IDLE_SYM(2'b00)
  ) u_b (
    .clk(clk),
    .rst(rst),
    .bus(b_if.slave)
`ifdef SHADOW_FSM_EN
    ,
    .pred_z(pz_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitors: every cycle is either an expected symbol or idle.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (qa.size() > 0 && qa[0].cyc == cyc) begin
        if ({a_if.sym_valid, a_if.x_1, a_if.x_2, a_if.last}
            !== {1'b1, qa[0].sym, qa[0].last}) begin
          errors++;
          $display("FAIL mon_a cyc=%0d got v,sym,last=%b exp=%b",
                   cyc, {a_if.sym_valid, a_if.x_1, a_if.x_2, a_if.last},
                   {1'b1, qa[0].sym, qa[0].last});
        end
        void'(qa.pop_front());
      end else if ({a_if.sym_valid, a_if.x_1, a_if.x_2, a_if.last}
                   !== 4'b0000) begin
        errors++;
        $display("FAIL mon_a_idle cyc=%0d got v,sym,last=%b exp=0000",
                 cyc, {a_if.sym_valid, a_if.x_1, a_if.x_2, a_if.last});
      end
      checks++;
      if (qb.size() > 0 && qb[0].cyc == cyc) begin
        if ({b_if.sym_valid, b_if.x_1, b_if.x_2, b_if.last}
            !== {1'b1, qb[0].sym, qb[0].last}) begin
          errors++;
          $display("FAIL mon_b cyc=%0d got v,sym,last=%b exp=%b",
                   cyc, {b_if.sym_valid, b_if.x_1, b_if.x_2, b_if.last},
                   {1'b1, qb[0].sym, qb[0].last});
        end
        void'(qb.pop_front());
      end else if ({b_if.sym_valid, b_if.x_1, b_if.x_2, b_if.last}
                   !== 4'b0000) begin
        errors++;
        $display("FAIL mon_b_idle cyc=%0d got v,sym,last=%b exp=0000",
                 cyc, {b_if.sym_valid, b_if.x_1, b_if.x_2, b_if.last});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected symbols of a full word starting at cycle c.
  task automatic push_word(input bit to_b, input int c,
                           input logic [7:0] w);
    for (int k = 0; k < 4; k++) begin
      exp_t e;
      logic [7:0] t;
      t = w << (2 * k);
      e.cyc  = c + k;
      e.sym  = t[7:6];
      e.last = (k == 3);
      if (to_b) qb.push_back(e);
      else qa.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_if.in_valid = 1'b0;
    a_if.in_data  = 8'h00;
    b_if.in_valid = 1'b0;
    b_if.in_data  = 8'h00;
    repeat (3) tick();
    rst = 1'b0;
    checks++;
    if ({a_if.in_ready, a_if.busy, a_if.sym_valid, a_if.last,
         a_if.x_1, a_if.x_2} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_a got rdy,busy,v,last,sym=%b exp=100000",
               {a_if.in_ready, a_if.busy, a_if.sym_valid, a_if.last,
                a_if.x_1, a_if.x_2});
    end
    checks++;
    if ({b_if.in_ready, b_if.busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_b got rdy,busy=%b exp=10",
               {b_if.in_ready, b_if.busy});
    end
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    int c0;
    c0 = cyc;
    a_if.in_valid = 1'b1;
    a_if.in_data  = 8'hB4;
    push_word(1'b0, c0 + 1, 8'hB4);
    tick();
    a_if.in_valid = 1'b0;
    a_if.in_data  = 8'h3C;
    for (int i = 1; i <= 6; i++) begin
      checks++;
      if ({a_if.in_ready, a_if.busy} !== {i == 6, i != 6}) begin
        errors++;
        $display("FAIL single_rdy_busy cycle %0d got %b exp %b",
                 i, {a_if.in_ready, a_if.busy}, {i == 6, i != 6});
      end
      if (i < 6) tick();
    end
  endtask

  task automatic test_back_to_back();
    int c0;
    c0 = cyc;
    a_if.in_valid = 1'b1;
    a_if.in_data  = 8'hFF;
    push_word(1'b0, c0 + 1, 8'hFF);
    push_word(1'b0, c0 + 7, 8'h00);
    tick();
    a_if.in_data = 8'h00;
    for (int i = 1; i <= 6; i++) begin
      checks++;
      if (a_if.in_ready !== (i == 6)) begin
        errors++;
        $display("FAIL b2b_ready cycle %0d got %b exp %b",
                 i, a_if.in_ready, (i == 6));
      end
      tick();
    end
    a_if.in_valid = 1'b0;
    a_if.in_data  = 8'h81;
    repeat (6) tick();
  endtask

  task automatic test_reset_mid();
    int c0;
    c0 = cyc;
    a_if.in_valid = 1'b1;
    a_if.in_data  = 8'hC3;
    qa.push_back('{c0 + 1, 2'b11, 1'b0});
    qa.push_back('{c0 + 2, 2'b00, 1'b0});
    tick();
    a_if.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if ({a_if.in_ready, a_if.busy} !== 2'b10) begin
      errors++;
      $display("FAIL rst_mid_ready got rdy,busy=%b exp=10",
               {a_if.in_ready, a_if.busy});
    end
    a_if.in_valid = 1'b1;
    a_if.in_data  = 8'h96;
    push_word(1'b0, cyc + 1, 8'h96);
    tick();
    a_if.in_valid = 1'b0;
    repeat (6) tick();
  endtask

  task automatic test_gap0();
    int c0;
    c0 = cyc;
    b_if.in_valid = 1'b1;
    b_if.in_data  = 8'h5A;
    push_word(1'b1, c0 + 1, 8'h5A);
    push_word(1'b1, c0 + 6, 8'hC3);
    tick();
    b_if.in_data = 8'hC3;
    for (int i = 1; i <= 5; i++) begin
      checks++;
      if (b_if.in_ready !== (i == 5)) begin
        errors++;
        $display("FAIL gap0_ready cycle %0d got %b exp %b",
                 i, b_if.in_ready, (i == 5));
      end
      tick();
    end
    b_if.in_valid = 1'b0;
    repeat (6) tick();
  endtask

`ifdef SHADOW_FSM_EN
  task automatic test_shadow();
    logic [1:0] exp_pq [8];
    exp_pq = '{2'b00, 2'b00, 2'b01, 2'b11,
               2'b10, 2'b10, 2'b00, 2'b00};
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    a_if.in_valid = 1'b1;
    a_if.in_data  = 8'hFF;
    push_word(1'b0, cyc + 1, 8'hFF);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (u_a.pq !== exp_pq[i] || pz_a !== (i == 3)) begin
        errors++;
        $display("FAIL shadow cycle %0d got pq=%b z=%b exp pq=%b z=%b",
                 i, u_a.pq, pz_a, exp_pq[i], (i == 3));
      end
      tick();
      a_if.in_valid = 1'b0;
    end
  endtask
`endif

  task automatic test_idle();
    a_if.in_valid = 1'b0;
    b_if.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({a_if.in_ready, a_if.busy} !== 2'b10) begin
        errors++;
        $display("FAIL idle cycle %0d got rdy,busy=%b exp=10",
                 i, {a_if.in_ready, a_if.busy});
      end
`ifdef SHADOW_FSM_EN
      checks++;
      if (pz_a !== 1'b0) begin
        errors++;
        $display("FAIL idle_pred_z cycle %0d got %b exp 0", i, pz_a);
      end
`endif
      tick();
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    mon_en = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
    test_gap0();
`ifdef SHADOW_FSM_EN
    test_shadow();
`endif
    test_idle();
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got a=%0d b=%0d pending exp 0",
               qa.size(), qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
